// File: rtl/modulator_xfade_select.sv
// modulator_xfade_select: N-channel sample selector that crossfades linearly over 2^RAMP_LOG2 strobes on a channel change
module modulator_xfade_select #(
   parameter int WIDTH     = 12,
   parameter int NCH       = 5,
   parameter int SEL_W     = 3,
   parameter int RAMP_LOG2 = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_en,
   input  logic [NCH*WIDTH-1:0]   sig_in,
   input  logic [SEL_W-1:0]       sel,
   output logic [WIDTH-1:0]       out_sig,
   output logic                   out_valid,
   output logic                   busy,
   output logic [SEL_W-1:0]       active_ch
);
   localparam logic IDLE = 1'b0;
   localparam logic FADE = 1'b1;
   localparam int   PW   = WIDTH + RAMP_LOG2;
   logic                 state;
   logic [RAMP_LOG2-1:0] k, wa;
   logic [SEL_W-1:0]     target, sel_eff;
   logic [WIDTH-1:0]     ch [2**SEL_W];
   logic [WIDTH-1:0]     src, dst, mix;
   logic [PW-1:0]        pa, pb;
   logic [PW:0]          sum;
   // unused select codes map to zero so the mux index never leaves the array
   genvar c;
   generate
      for (c = 0; c < 2**SEL_W; c++) begin : g_ch
         if (c < NCH) begin : g_on
            assign ch[c] = sig_in[c*WIDTH +: WIDTH];
         end else begin : g_off
            assign ch[c] = '0;
         end
      end
   endgenerate
   // k is 1..R-1 during a fade, so R-k fits in RAMP_LOG2 bits as -k
   always_comb begin
      sel_eff = ({1'b0, sel} < (SEL_W+1)'(NCH)) ? sel : '0;
      src     = ch[active_ch];
      dst     = ch[target];
      wa      = -k;
      pa      = PW'(src) * PW'(wa);
      pb      = PW'(dst) * PW'(k);
      sum     = (PW+1)'(pa) + (PW+1)'(pb);
      mix     = WIDTH'(sum >> RAMP_LOG2);
   end
   assign busy = (state == FADE);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         target    <= '0;
         active_ch <= '0;
         out_sig   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= sample_en;
         if (sample_en) begin
            if (state == IDLE) begin
               out_sig <= src;
               if (sel_eff != active_ch) begin
                  target <= sel_eff;
                  k      <= RAMP_LOG2'(1);
                  state  <= FADE;
               end
            end else begin
               out_sig <= mix;
               if (&k) begin
                  active_ch <= target;
                  state     <= IDLE;
               end else begin
                  k <= k + 1'b1;
               end
            end
         end
      end
   end
endmodule
